// File: rtl/dmem_arbiter.sv
// -----------------------------------------------------------------------------
// dmem_arbiter
//
// Arbiter and sequencer for the single 128x16 data memory port. Requester 0 is
// the data cache (block read, block write-back), requester 1 is the
// instruction cache (block read only). One requester owns the memory port for
// a whole transaction: the arbiter latches the winner's command, address and
// write data into the mem_* registers, follows the memory's busy handshake,
// returns read data into that requester's holding register and stalls any
// requester that is not being completed this cycle.
//
// Transaction sequence: IDLE -> ISSUE -> WAIT -> DONE -> IDLE.
//   ISSUE waits for mem_busy to rise, WAIT waits for it to fall, DONE is the
//   single cycle in which the owner sees busy low and the read data is valid.
//
// Build option:
//   ARB_ROUND_ROBIN_EN  defined   -> ties between the two requesters go to
//                                    the one not served last.
//                       undefined -> fixed priority, requester 0 wins ties.
//
// Ports:
//   clk, rst             clock (posedge) and asynchronous active-high reset
//   r0_read, r0_write    data-cache request levels (both high = no request)
//   r0_addr, r0_wdata    data-cache block address / write block
//   r0_rdata, r0_busy    last block read for requester 0 / stall
//   r1_read, r1_addr     instruction-cache read request level / address
//   r1_rdata, r1_busy    last block read for requester 1 / stall
//   mem_read, mem_write  registered memory commands
//   mem_addr, mem_wdata  registered memory address / write data
//   mem_rdata, mem_busy  memory read data / access-in-progress flag
//   grant                one-hot owner of the memory port, 00 when idle
// -----------------------------------------------------------------------------
module dmem_arbiter #(
    parameter int ADDR_W = 7,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              r0_read,
    input  logic              r0_write,
    input  logic [ADDR_W-1:0] r0_addr,
    input  logic [DATA_W-1:0] r0_wdata,
    output logic [DATA_W-1:0] r0_rdata,
    output logic              r0_busy,
    input  logic              r1_read,
    input  logic [ADDR_W-1:0] r1_addr,
    output logic [DATA_W-1:0] r1_rdata,
    output logic              r1_busy,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_busy,
    output logic [1:0]        grant
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t state;

    logic req0;
    logic req1;
    logic pick1;
    logic done0;
    logic done1;

    // A data-cache request with both read and write raised is malformed and
    // is treated as no request at all.
    assign req0 = r0_read ^ r0_write;
    assign req1 = r1_read;

`ifdef ARB_ROUND_ROBIN_EN
    // Last-served pointer: 1 means requester 1 was granted most recently.
    logic last1;

    // On a tie the requester not served last wins; a lone requester always
    // wins.
    assign pick1 = req1 && (!req0 || !last1);
`else
    assign pick1 = req1 && !req0;
`endif

    // A requester is released only in the DONE cycle of its own transaction.
    assign done0   = (state == DONE) && grant[0];
    assign done1   = (state == DONE) && grant[1];
    assign r0_busy = req0 && !done0;
    assign r1_busy = req1 && !done1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            grant     <= 2'b00;
            r0_rdata  <= '0;
            r1_rdata  <= '0;
`ifdef ARB_ROUND_ROBIN_EN
            last1     <= 1'b1;
`endif
        end else begin
            case (state)
                // Arbitrate and latch the whole command for the winner; the
                // mem_* registers then stay frozen until the next IDLE.
                IDLE: begin
                    if (req0 || req1) begin
                        state <= ISSUE;
                        if (pick1) begin
                            grant     <= 2'b10;
                            mem_read  <= 1'b1;
                            mem_write <= 1'b0;
                            mem_addr  <= r1_addr;
                            mem_wdata <= '0;
                        end else begin
                            grant     <= 2'b01;
                            mem_read  <= r0_read;
                            mem_write <= r0_write;
                            mem_addr  <= r0_addr;
                            mem_wdata <= r0_wdata;
                        end
`ifdef ARB_ROUND_ROBIN_EN
                        last1 <= pick1;
`endif
                    end
                end

                // Command is on the bus; wait for the memory to accept it.
                ISSUE: begin
                    if (mem_busy) begin
                        state <= WAIT;
                    end
                end

                // Access in progress; on completion route read data to the
                // owner only, so the other holding register keeps its block.
                WAIT: begin
                    if (!mem_busy) begin
                        if (mem_read) begin
                            if (grant[1]) begin
                                r1_rdata <= mem_rdata;
                            end else begin
                                r0_rdata <= mem_rdata;
                            end
                        end
                        mem_read  <= 1'b0;
                        mem_write <= 1'b0;
                        state     <= DONE;
                    end
                end

                // Owner is released for this one cycle; ownership ends here,
                // which forces one idle cycle between transactions.
                DONE: begin
                    grant <= 2'b00;
                    state <= IDLE;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_dmem_arbiter
//
// Bench for dmem_arbiter. A small memory model answers commands with a
// four-edge busy pulse and serves mem[addr]. A transaction-level reference
// model predicts every output each cycle; directed sequences pin literal
// values, then randomized requesters run against the model.
// -----------------------------------------------------------------------------
module tb_dmem_arbiter;

    localparam int ADDR_W = 7;
    localparam int DATA_W = 16;
`ifdef ARB_ROUND_ROBIN_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic              clk;
    logic              rst;
    logic              r0_read;
    logic              r0_write;
    logic [ADDR_W-1:0] r0_addr;
    logic [DATA_W-1:0] r0_wdata;
    logic [DATA_W-1:0] r0_rdata;
    logic              r0_busy;
    logic              r1_read;
    logic [ADDR_W-1:0] r1_addr;
    logic [DATA_W-1:0] r1_rdata;
    logic              r1_busy;
    logic              mem_read;
    logic              mem_write;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_busy;
    logic [1:0]        grant;

    int n_checks = 0;
    int n_errs   = 0;

    dmem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .r0_read   (r0_read),
        .r0_write  (r0_write),
        .r0_addr   (r0_addr),
        .r0_wdata  (r0_wdata),
        .r0_rdata  (r0_rdata),
        .r0_busy   (r0_busy),
        .r1_read   (r1_read),
        .r1_addr   (r1_addr),
        .r1_rdata  (r1_rdata),
        .r1_busy   (r1_busy),
        .mem_read  (mem_read),
        .mem_write (mem_write),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_busy  (mem_busy),
        .grant     (grant)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] init_word(input int i);
        logic [15:0] w;
        w = 16'(i * 40503) ^ 16'h5A5A;
        if (i == 'h19) w = 16'h412D;
        if (i == 'h42) w = 16'h1E77;
        if (i == 'h33) w = 16'hA5C3;
        return w;
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errs++;
            if (n_errs <= 40)
                $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // ---------------- memory model ----------------
    logic [15:0] mem_arr [128];
    int          busy_cnt;

    assign mem_busy  = (mem_read | mem_write) && (busy_cnt < 4);
    assign mem_rdata = mem_arr[mem_addr];

    initial begin
        busy_cnt <= 0;
        for (int i = 0; i < 128; i++) mem_arr[i] <= init_word(i);
        forever begin
            @(posedge clk);
            if (mem_read | mem_write) begin
                if (busy_cnt < 4) busy_cnt <= busy_cnt + 1;
                else if (mem_write) mem_arr[mem_addr] <= mem_wdata;
            end else begin
                busy_cnt <= 0;
            end
        end
    end

    // ---------------- reference model ----------------
    // A transaction occupies 6 cycles after its issue edge: ages 0..4 with
    // the command on the bus, age 5 is the release cycle, then idle.
    bit          m_act;
    int          m_age;
    bit          m_who;
    bit          m_wr;
    logic [6:0]  m_addr;
    logic [15:0] m_wdata;
    logic [15:0] m_rd0;
    logic [15:0] m_rd1;
    bit          m_last;
    int          served0;
    int          served1;
    logic [15:0] ref_mem [128];

    task automatic model_step();
        bit q0;
        bit q1;
        bit w;
        if (rst) begin
            m_act = 0; m_age = 0; m_addr = '0; m_wdata = '0;
            m_rd0 = '0; m_rd1 = '0; m_last = 1'b1;
        end else if (m_act) begin
            m_age++;
            if (m_age == 5) begin
                if (m_wr) ref_mem[m_addr] = m_wdata;
                else if (m_who) m_rd1 = ref_mem[m_addr];
                else m_rd0 = ref_mem[m_addr];
            end
            if (m_age == 6) begin
                m_act = 0;
                if (m_who) served1++; else served0++;
            end
        end else begin
            q0 = r0_read ^ r0_write;
            q1 = r1_read;
            if (q0 | q1) begin
                if (q0 & q1) w = RR ? ~m_last : 1'b0;
                else w = q1;
                m_act   = 1;
                m_age   = 0;
                m_who   = w;
                m_wr    = !w && r0_write;
                m_addr  = w ? r1_addr : r0_addr;
                m_wdata = w ? 16'h0 : r0_wdata;
                m_last  = w;
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 128; i++) ref_mem[i] = init_word(i);
        m_act = 0; m_age = 0; m_who = 0; m_wr = 0; m_addr = '0; m_wdata = '0;
        m_rd0 = '0; m_rd1 = '0; m_last = 1'b1; served0 = 0; served1 = 0;
        forever begin
            @(posedge clk or posedge rst);
            model_step();
        end
    end

    // ---------------- compare process ----------------
    task automatic compare_all();
        bit         cmd;
        logic [1:0] e_grant;
        cmd     = m_act && (m_age <= 4);
        e_grant = m_act ? (m_who ? 2'b10 : 2'b01) : 2'b00;
        chk("mem_read",  32'(mem_read),  32'(cmd && !m_wr));
        chk("mem_write", 32'(mem_write), 32'(cmd && m_wr));
        chk("mem_addr",  32'(mem_addr),  32'(m_addr));
        if (cmd && m_wr) chk("mem_wdata", 32'(mem_wdata), 32'(m_wdata));
        chk("grant",     32'(grant),     32'(e_grant));
        chk("r0_rdata",  32'(r0_rdata),  32'(m_rd0));
        chk("r1_rdata",  32'(r1_rdata),  32'(m_rd1));
        chk("r0_busy",   32'(r0_busy),
            32'((r0_read ^ r0_write) && !(m_act && m_age == 5 && !m_who)));
        chk("r1_busy",   32'(r1_busy),
            32'(r1_read && !(m_act && m_age == 5 && m_who)));
    endtask

    initial begin
        forever begin
            @(negedge clk);
            compare_all();
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    int mode0 = 0;
    int mode1 = 0;
    int cd0   = 0;
    int seen0 = 0;
    int seen1 = 0;

    task automatic agent_step();
        if (mode0 == 1 && served0 != seen0) begin
            seen0 = served0; mode0 = 0; r0_read = 0; r0_write = 0;
        end else if (mode0 == 2) begin
            cd0--;
            if (cd0 <= 0) begin mode0 = 0; r0_read = 0; r0_write = 0; end
        end
        if (mode0 == 0 && $urandom_range(0, 2) == 0) begin
            r0_addr  = 7'($urandom_range(0, 15));
            r0_wdata = 16'($urandom);
            case ($urandom_range(0, 9))
                0: begin mode0 = 2; cd0 = $urandom_range(1, 4); r0_read = 1; r0_write = 1; end
                1, 2, 3, 4: begin mode0 = 1; r0_read = 1; r0_write = 0; end
                default: begin mode0 = 1; r0_read = 0; r0_write = 1; end
            endcase
        end
        if (mode1 == 1 && served1 != seen1) begin
            seen1 = served1; mode1 = 0; r1_read = 0;
        end
        if (mode1 == 0 && $urandom_range(0, 2) == 0) begin
            r1_addr = 7'($urandom_range(0, 15));
            r1_read = 1;
            mode1   = 1;
        end
    endtask

    int n;

    initial begin
        rst = 1'b1;
        r0_read = 0; r0_write = 0; r0_addr = '0; r0_wdata = '0;
        r1_read = 0; r1_addr = '0;
        repeat (3) @(posedge clk);
        #2;
        chk("rst_grant",    32'(grant),     32'h0);
        chk("rst_mem_read", 32'(mem_read),  32'h0);
        chk("rst_mem_addr", 32'(mem_addr),  32'h0);
        chk("rst_r0_rdata", 32'(r0_rdata),  32'h0);
        rst = 1'b0;
        tick();

        // r0 read of 0x19
        r0_read = 1; r0_addr = 7'h19;
        tick();
        chk("t1_grant", 32'(grant), 32'h1);
        chk("t1_addr",  32'(mem_addr), 32'h19);
        n = 0;
        for (int k = 0; k < 5; k++) begin
            if (mem_read) n++;
            tick();
        end
        chk("t1_read_cycles", 32'(n), 32'd5);
        chk("t1_done_mem_read", 32'(mem_read), 32'h0);
        chk("t1_done_rdata", 32'(r0_rdata), 32'h412D);
        chk("t1_done_busy",  32'(r0_busy),  32'h0);
        chk("t1_done_grant", 32'(grant),    32'h1);
        tick();
        chk("t1_idle_grant", 32'(grant), 32'h0);
        r0_read = 0;

        // r0 write 0x0C then r1 read 0x0C
        r0_write = 1; r0_addr = 7'h0C; r0_wdata = 16'h5F41;
        tick();
        chk("t2_wr_grant", 32'(grant), 32'h1);
        chk("t2_wr_cmd",   32'(mem_write), 32'h1);
        chk("t2_wr_data",  32'(mem_wdata), 32'h5F41);
        repeat (5) tick();
        chk("t2_wr_done_busy", 32'(r0_busy), 32'h0);
        tick();
        r0_write = 0; r1_read = 1; r1_addr = 7'h0C;
        tick();
        chk("t2_rd_grant", 32'(grant), 32'h2);
        repeat (5) tick();
        chk("t2_r1_rdata", 32'(r1_rdata), 32'h5F41);
        chk("t2_r0_rdata", 32'(r0_rdata), 32'h412D);
        chk("t2_r1_busy",  32'(r1_busy),  32'h0);
        tick();
        r1_read = 0;
        tick();

        // simultaneous requests
        r0_read = 1; r0_addr = 7'h21; r1_read = 1; r1_addr = 7'h42;
        tick();
        chk("t3_grant0", 32'(grant), 32'h1);
        chk("t3_addr0",  32'(mem_addr), 32'h21);
        for (int k = 0; k < 5; k++) begin
            chk("t3_r1_stall", 32'(r1_busy), 32'h1);
            tick();
        end
        chk("t3_r0_release", 32'(r0_busy), 32'h0);
        chk("t3_r1_done_stall", 32'(r1_busy), 32'h1);
        tick();
        r0_read = 0;
        chk("t3_gap_grant", 32'(grant), 32'h0);
        tick();
        chk("t3_grant1", 32'(grant), 32'h2);
        chk("t3_addr1",  32'(mem_addr), 32'h42);
        repeat (5) tick();
        chk("t3_r1_rdata", 32'(r1_rdata), 32'h1E77);
        tick();
        r1_read = 0;
        tick();

        // malformed r0 request, then r1 in parallel
        r0_read = 1; r0_write = 1; r0_addr = 7'h05;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("t5_grant",   32'(grant),     32'h0);
            chk("t5_cmd",     32'(mem_read | mem_write), 32'h0);
            chk("t5_r0_busy", 32'(r0_busy),   32'h0);
        end
        r1_read = 1; r1_addr = 7'h19;
        tick();
        chk("t5_r1_grant", 32'(grant), 32'h2);
        chk("t5_r1_read",  32'(mem_read), 32'h1);
        chk("t5_r0_free",  32'(r0_busy), 32'h0);
        repeat (5) tick();
        chk("t5_r1_rdata", 32'(r1_rdata), 32'h412D);
        tick();
        r0_read = 0; r0_write = 0; r1_read = 0;
        tick();

        // reset during WAIT of an r1 read
        r1_read = 1; r1_addr = 7'h33;
        tick();
        tick();
        tick();
        #1 rst = 1'b1;
        #1;
        chk("t6_rst_mem_read", 32'(mem_read), 32'h0);
        chk("t6_rst_grant",    32'(grant),    32'h0);
        chk("t6_rst_r1_rdata", 32'(r1_rdata), 32'h0);
        chk("t6_rst_r0_rdata", 32'(r0_rdata), 32'h0);
        @(posedge clk);
        #2 rst = 1'b0;
        tick();
        chk("t6_reissue_grant", 32'(grant), 32'h2);
        chk("t6_reissue_addr",  32'(mem_addr), 32'h33);
        repeat (5) tick();
        chk("t6_r1_rdata", 32'(r1_rdata), 32'hA5C3);
        tick();
        r1_read = 0;
        tick();

        // both requesters continuously reading
        r0_read = 1; r0_addr = 7'h10; r1_read = 1; r1_addr = 7'h11;
        for (int k = 0; k < 6; k++) begin
            tick();
            chk("t4_grant_seq", 32'(grant), (RR && (k % 2 == 1)) ? 32'h2 : 32'h1);
            repeat (6) tick();
        end
        r0_read = 0; r1_read = 0;
        tick();

        // randomized traffic
        seen0 = served0; seen1 = served1;
        mode0 = 0; mode1 = 0;
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 299) == 0) begin
                rst = 1'b1;
                @(posedge clk);
                #2 rst = 1'b0;
            end else begin
                agent_step();
                tick();
            end
        end
        r0_read = 0; r0_write = 0; r1_read = 0;
        repeat (8) tick();

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-port arbiter and sequencer for the single 128x16 data memory port. Requester 0 is the data cache (read/write, dirty write-back and block fetch); requester 1 is the instruction cache (read-only block fetch). The arbiter picks one requester, drives the memory's read/write/address/data lines for the whole transaction, tracks the memory's busy handshake, returns read data into a per-requester holding register, and stalls the losing requester via its busy output.

## Interface
- ADDR_W, 7, block address width (128 blocks)
- DATA_W, 16, block width in bits
- clk  in  1  clock, all state updates on posedge
- rst  in  1  reset, asynchronous, active-high
- r0_read  in  1  data-cache block read request (level, held until served)
- r0_write  in  1  data-cache block write request (level, held until served)
- r0_addr  in  ADDR_W  data-cache block address, stable while requesting
- r0_wdata  in  DATA_W  data-cache write block, stable while requesting
- r0_rdata  out  DATA_W  last block read for requester 0 (registered)
- r0_busy  out  1  requester 0 stall
- r1_read  in  1  instruction-cache block read request
- r1_addr  in  ADDR_W  instruction-cache block address
- r1_rdata  out  DATA_W  last block read for requester 1 (registered)
- r1_busy  out  1  requester 1 stall
- mem_read, mem_write  out  1  memory commands (registered)
- mem_addr  out  ADDR_W  memory address (registered)
- mem_wdata  out  DATA_W  memory write data (registered)
- mem_rdata  in  DATA_W  memory read data
- mem_busy  in  1  memory busy, high while an access is in progress
- grant  out  2  one-hot owner of the memory port, 00 when idle

## Operation
- Valid requests: req0 = r0_read XOR r0_write; req1 = r1_read. If r0_read and r0_write are both high, there is no request: no memory activity and r0_busy=0.
- States: IDLE, ISSUE, WAIT, DONE.
- IDLE: if any valid request is present, select a winner, latch its addr/wdata/command into the mem_* registers, set grant, and go to ISSUE. Otherwise stay in IDLE.
- ISSUE: mem_read/mem_write held. If mem_busy is sampled 1, go to WAIT. Otherwise stay in ISSUE.
- WAIT: mem_* held. If mem_busy is sampled 0, capture mem_rdata into the winner's rN_rdata (reads only), clear mem_read/mem_write, and go to DONE.
- DONE: one cycle, then go to IDLE. grant clears on the DONE→IDLE edge.
- rN_busy = reqN AND NOT (state==DONE AND grant[N]). A requester sees busy=0 for exactly the DONE cycle and must drop or change its request after that edge.
- rN_rdata holds its value until the next completed read for that requester. Writes leave it unchanged.
- mem_addr and mem_wdata never change while state is not IDLE. A request arriving mid-transaction waits.
- Selection is fixed priority, requester 0 over requester 1, unless the Configuration macro is defined.
- Reset (asynchronous, any state including mid-WAIT): state=IDLE; mem_read=mem_write=0; mem_addr=0, mem_wdata=0; grant=00; r0_rdata=r1_rdata=0; round-robin pointer points to requester 1 as last served. The interrupted transaction is abandoned. A request still held after reset is re-arbitrated from IDLE.

## Timing
- Request high before edge E0 (state IDLE): mem_read/mem_write high after E0.
- Memory holding busy high for N sampled edges: DONE entered at edge E0+N+1, IDLE at E0+N+2, earliest next ISSUE at E0+N+3. There is one idle cycle between transactions.
- Data read through the memory port is valid in rN_rdata from the DONE cycle onward.
- r0_busy and r1_busy are combinational from the requests and registered state. The requester stalls in the same cycle it raises a request.

## Configuration
- ARB_ROUND_ROBIN_EN defined: a 1-bit last-served pointer updates on each grant. When both requesters are valid in IDLE, the one not served last wins. With a single requester, that requester wins.
- ARB_ROUND_ROBIN_EN undefined: fixed priority, requester 0 always wins ties. The pointer logic is not built.

## Test plan
Bench memory model: mem_busy rises in the same cycle a command appears, stays high for 4 edges, and read returns mem[addr].
- r0 read, addr 0x19, mem[0x19]=0x412D -> grant=01, mem_addr=0x19, mem_read=1 for 5 cycles; r0_rdata=0x412D and r0_busy=0 in DONE; grant=00 one cycle later.
- r0 write, addr 0x0C, wdata 0x5F41, then r1 read of 0x0C -> mem[0x0C]=0x5F41; r1_rdata=0x5F41; r0_rdata unchanged.
- r0 read and r1 read both raised at the same edge, fixed priority -> r0 served first, r1_busy held high throughout; r1 granted 2 cycles after r0's DONE; mem_addr stable during each transaction.
- ARB_ROUND_ROBIN_EN, both requesters continuously issuing 6 reads -> grant sequence 01,10,01,10,01,10; no requester waits more than one transaction.
- r0_read and r0_write both high -> no mem command, grant=00, r0_busy=0; r1 read in the same cycle is still served.
- rst pulsed during WAIT of an r1 read -> mem_read=0 and grant=00 immediately, r1_rdata=0; after rst falls, the held r1 request is re-issued from IDLE and completes normally.
